fft256_seq_ctrl: RTL and testbench

//  Sequencer for the in-place, memory-based radix-2 DIT 256-point FFT datapath.
//  - Loads one 256-sample frame into sample RAM at bit-reversed addresses.
//  - Issues 8 stages x 128 butterflies (addresses, twiddle index, stage) to the butterfly unit.
//  - Tracks the butterfly pipeline and reads results out in natural order, with out_valid.

---
 rtl/fft256_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fft256_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft256_seq_ctrl.sv
// Load/compute/drain/unload sequencer for a memory-based 256-point radix-2 DIT FFT.
// Define FFT_CTRL_OVERRUN_CHK_EN to build the sticky err_overrun detector.
module fft256_seq_ctrl #(
  parameter int N      = 256,
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_addr,
  output logic             bf_valid,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [2:0]       bf_stage,
  output logic             wb_we,
  output logic [LOG2N-1:0] wb_addr_a,
  output logic [LOG2N-1:0] wb_addr_b,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr,
  output logic             out_valid,
  output logic             busy,
  output logic             err_overrun
);

  localparam int AW = LOG2N;
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);
  localparam logic [AW-1:0] J_LAST   = AW'(N / 2 - 1);
  localparam logic [AW-1:0] DR_LAST  = AW'(BF_LAT - 1);
  localparam logic [2:0]    ST_LAST  = 3'(LOG2N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [2:0] stage, stage_n;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    for (int i = 0; i < AW; i++) bitrev[i] = v[AW-1-i];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stage     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stage     <= stage_n;
      out_valid <= rd_en;
    end
  end

  // One counter serves as sample count, j, drain count and read address.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stage_n  = stage;
    ld_we    = 1'b0;
    bf_valid = 1'b0;
    rd_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          ld_we   = 1'b1;
          state_n = S_LOAD;
          cnt_n   = AW'(1);
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          ld_we = 1'b1;
          if (cnt == CNT_LAST) begin
            state_n = S_COMPUTE;
            cnt_n   = '0;
            stage_n = '0;
          end else begin
            cnt_n = cnt + AW'(1);
          end
        end
      end
      S_COMPUTE: begin
        bf_valid = 1'b1;
        if (cnt == J_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DR_LAST) begin
          cnt_n = '0;
          if (stage == ST_LAST) begin
            state_n = S_UNLOAD;
          end else begin
            state_n = S_COMPUTE;
            stage_n = stage + 3'd1;
          end
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      S_UNLOAD: begin
        rd_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          stage_n = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  logic [AW-1:0] jw, half, jm, a_c;
  logic [3:0] sh_a;
  logic [2:0] sh_t;

  always_comb begin
    jw   = {1'b0, cnt[AW-2:0]};
    half = AW'(1) << stage;
    jm   = jw & (half - AW'(1));
    sh_a = 4'(stage) + 4'd1;
    sh_t = ST_LAST - stage;
    a_c  = ((jw >> stage) << sh_a) | jm;
  end

  assign ld_addr   = ld_we ? bitrev(cnt) : '0;
  assign bf_addr_a = bf_valid ? a_c : '0;
  assign bf_addr_b = bf_valid ? a_c + half : '0;
  assign tw_idx    = bf_valid ? (AW-1)'(jm << sh_t) : '0;
  assign bf_stage  = stage;
  assign rd_addr   = rd_en ? cnt : '0;
  assign busy      = (state != S_IDLE);

  logic [BF_LAT-1:0] wv;
  logic [AW-1:0] wa [BF_LAT];
  logic [AW-1:0] wbb [BF_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wv <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        wa[i]  <= '0;
        wbb[i] <= '0;
      end
    end else begin
      wv[0]  <= bf_valid;
      wa[0]  <= bf_addr_a;
      wbb[0] <= bf_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        wv[i]  <= wv[i-1];
        wa[i]  <= wa[i-1];
        wbb[i] <= wbb[i-1];
      end
    end
  end

  assign wb_we     = wv[BF_LAT-1];
  assign wb_addr_a = wa[BF_LAT-1];
  assign wb_addr_b = wbb[BF_LAT-1];

`ifdef FFT_CTRL_OVERRUN_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_valid && (state == S_COMPUTE ||
                 state == S_DRAIN || state == S_UNLOAD)) begin
      err_q <= 1'b1;
    end
  end
  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fft256_seq_ctrl.sv
// Scoreboard bench for fft256_seq_ctrl: a frame-level model queues expected
// load/butterfly/writeback/unload events, a negedge monitor consumes them.
`timescale 1ns/1ps
module tb_fft256_seq_ctrl;
  localparam int BF_LAT = 3;
  localparam int SPAN   = 128 + BF_LAT;
  localparam int BIG    = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic ld_we, bf_valid, wb_we, rd_en, out_valid, busy, err_overrun;
  logic [7:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr;
  logic [6:0] tw_idx;
  logic [2:0] bf_stage;

  fft256_seq_ctrl #(.N(256), .LOG2N(8), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .tw_idx(tw_idx), .bf_stage(bf_stage),
    .wb_we(wb_we), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .out_valid(out_valid),
    .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
    logic [2:0] s;
  } bf_t;

  typedef struct {
    int t;
    logic [7:0] a;
  } ev_t;

  ev_t ld_q[$];
  ev_t rd_q[$];
  bf_t bf_q[$];
  bf_t wb_q[$];
  bf_t pend[$];
  int  ov_q[$];

  int checks = 0;
  int failures = 0;
  int err_cyc = BIG;
  bit mon_en = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic int rev8(input int k);
    int r = 0;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  // Textbook DIT schedule: per stage, groups of 2*span, butterflies inside.
  task automatic expect_frame(input int last);
    bf_t f;
    ev_t e;
    int j, span;
    for (int s = 0; s < 8; s++) begin
      span = 1 << s;
      j = 0;
      for (int k = 0; k < 256; k += 2 * span) begin
        for (int m = 0; m < span; m++) begin
          f.t  = last + 1 + s * SPAN + j;
          f.a  = 8'(k + m);
          f.b  = 8'(k + m + span);
          f.tw = 7'(m * (128 >> s));
          f.s  = 3'(s);
          bf_q.push_back(f);
          f.t  = f.t + BF_LAT;
          wb_q.push_back(f);
          j++;
        end
      end
    end
    for (int i = 0; i < 256; i++) begin
      e.t = last + 1 + 8 * SPAN + i;
      e.a = 8'(i);
      rd_q.push_back(e);
      ov_q.push_back(e.t + 1);
    end
  endtask

  ev_t me;
  bf_t mf;
  int  hz;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ld_we) begin
        if (ld_q.size() == 0) chk("ld_extra", 1, 0);
        else begin
          me = ld_q.pop_front();
          chk("ld_cyc", cyc, me.t);
          chk("ld_addr", int'(ld_addr), int'(me.a));
        end
      end
      if (bf_valid) begin
        hz = 0;
        foreach (pend[i])
          if (pend[i].s != bf_stage &&
              (pend[i].a == bf_addr_a || pend[i].a == bf_addr_b ||
               pend[i].b == bf_addr_a || pend[i].b == bf_addr_b))
            hz = 1;
        chk("hazard", hz, 0);
        mf.t = cyc; mf.a = bf_addr_a; mf.b = bf_addr_b;
        mf.tw = tw_idx; mf.s = bf_stage;
        pend.push_back(mf);
        if (bf_q.size() == 0) chk("bf_extra", 1, 0);
        else begin
          mf = bf_q.pop_front();
          chk("bf_cyc", cyc, mf.t);
          chk("bf_addr_a", int'(bf_addr_a), int'(mf.a));
          chk("bf_addr_b", int'(bf_addr_b), int'(mf.b));
          chk("tw_idx", int'(tw_idx), int'(mf.tw));
          chk("bf_stage", int'(bf_stage), int'(mf.s));
        end
      end
      if (wb_we) begin
        if (pend.size() != 0) void'(pend.pop_front());
        if (wb_q.size() == 0) chk("wb_extra", 1, 0);
        else begin
          mf = wb_q.pop_front();
          chk("wb_cyc", cyc, mf.t);
          chk("wb_addr_a", int'(wb_addr_a), int'(mf.a));
          chk("wb_addr_b", int'(wb_addr_b), int'(mf.b));
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          me = rd_q.pop_front();
          chk("rd_cyc", cyc, me.t);
          chk("rd_addr", int'(rd_addr), int'(me.a));
        end
      end
      if (out_valid) begin
        if (ov_q.size() == 0) chk("ov_extra", 1, 0);
        else chk("ov_cyc", cyc, ov_q.pop_front());
      end
      chk("err_overrun", int'(err_overrun), int'(cyc > err_cyc));
    end
  end

  task automatic send_frame(input int mode, output int last);
    int k = 0;
    bit ph = 1'b1;
    bit v;
    ev_t e;
    last = 0;
    while (k < 256) begin
      @(posedge clk); #1;
      case (mode)
        0: v = 1'b1;
        1: begin v = ph; ph = ~ph; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      if (v) begin
        e.t = cyc;
        e.a = 8'(rev8(k));
        ld_q.push_back(e);
        if (k == 255) begin
          last = cyc;
          expect_frame(cyc);
        end
        k++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_at(input int t);
    to_cycle(t);
    in_valid = 1'b1;
`ifdef FFT_CTRL_OVERRUN_CHK_EN
    if (err_cyc > cyc) err_cyc = cyc;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    chk("idle_timeout", int'(busy), 0);
    @(posedge clk); #1;
    chk("ld_left", ld_q.size(), 0);
    chk("bf_left", bf_q.size(), 0);
    chk("wb_left", wb_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("ov_left", ov_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int last, r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ctrl", int'({ld_we, bf_valid, wb_we, rd_en, out_valid, busy, err_overrun}), 0);
    chk("rst_addr", int'(|{ld_addr, bf_addr_a, bf_addr_b, tw_idx, bf_stage,
                            wb_addr_a, wb_addr_b, rd_addr}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    @(posedge clk); #1;

    send_frame(0, last);
    to_cycle(last + 1 + 2 * SPAN + 5);
    @(negedge clk);
    chk("s2j5_a", int'(bf_addr_a), 9);
    chk("s2j5_b", int'(bf_addr_b), 13);
    chk("s2j5_tw", int'(tw_idx), 32);
    to_cycle(last + 1 + 7 * SPAN + 127);
    @(negedge clk);
    chk("s7j127_a", int'(bf_addr_a), 127);
    chk("s7j127_b", int'(bf_addr_b), 255);
    chk("s7j127_tw", int'(tw_idx), 127);
    wait_idle();

    send_frame(1, last);
    wait_idle();

    send_frame(2, last);
    pulse_at(last + 10);
    pulse_at(last + 130);
    pulse_at(last + 8 * SPAN + 40);
    wait_idle();

    send_frame(0, last);
    r = last + 1 + 8 * SPAN + 100;
    to_cycle(r);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_cyc = BIG;
    while (rd_q.size() != 0 && rd_q[$].t > r) void'(rd_q.pop_back());
    while (ov_q.size() != 0 && ov_q[$] > r) void'(ov_q.pop_back());
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_rd_en", int'(rd_en), 0);
    chk("midrst_busy", int'(busy), 0);
    wait_idle();

    send_frame(2, last);
    wait_idle();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
